// File: rtl/carregador_programa.sv
// Program loader: byte stream -> big-endian 32-bit words written to instruction memory.
// Optional trailing XOR checksum byte enabled with `define CHECKSUM_EN.
module carregador_programa #(
    parameter int          ADDR_W    = 8,
    parameter logic [31:0] BASE_ADDR = 32'h0
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [7:0]      byteIn,
    input  logic            byteValid,
    output logic            byteReady,
    output logic            memEsc,
    output logic [31:0]     memEnd,
    output logic [31:0]     memDados,
    output logic [ADDR_W:0] palavras,
    output logic            pronto,
    output logic            erro
);

`ifdef CHECKSUM_EN
    typedef enum logic [2:0] {
        CONTA_H, CONTA_L, DADOS, CHECK, FEITO, ERRO
    } estado_t;
`else
    typedef enum logic [2:0] {
        CONTA_H, CONTA_L, DADOS, FEITO, ERRO
    } estado_t;
`endif

    localparam logic [16:0] MAX_PAL = 17'(1) << ADDR_W;

    estado_t estado, proxEstado;

    logic        aceita;
    logic        xfer;
    logic        escPalavra;
    logic        ultima;
    logic [7:0]  contaAlta;
    logic [16:0] total;
    logic [16:0] nVal;
    logic [1:0]  fase;
    logic [23:0] parcial;
    logic [31:0] endProx;
`ifdef CHECKSUM_EN
    logic [7:0]  soma;
`endif

    // Reset holds byteReady low even though the state already reads CONTA_H.
    assign aceita = !reset && (estado == CONTA_H || estado == CONTA_L ||
`ifdef CHECKSUM_EN
                               estado == CHECK ||
`endif
                               estado == DADOS);

    assign byteReady = aceita;
    assign xfer      = byteValid && aceita;
    assign nVal      = {1'b0, contaAlta, byteIn};
    assign ultima    = (17'(palavras) + 17'd1) == total;

    assign pronto = (estado == FEITO) && !memEsc;
    assign erro   = (estado == ERRO);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado <= CONTA_H;
        end else begin
            estado <= proxEstado;
        end
    end

    always_comb begin
        proxEstado = estado;
        escPalavra = 1'b0;
        unique case (estado)
            CONTA_H: begin
                if (xfer) proxEstado = CONTA_L;
            end
            CONTA_L: begin
                if (xfer) begin
                    if (nVal > MAX_PAL) begin
                        proxEstado = ERRO;
                    end else if (nVal == 17'd0) begin
`ifdef CHECKSUM_EN
                        proxEstado = CHECK;
`else
                        proxEstado = FEITO;
`endif
                    end else begin
                        proxEstado = DADOS;
                    end
                end
            end
            DADOS: begin
                if (xfer && fase == 2'd3) begin
                    escPalavra = 1'b1;
                    if (ultima) begin
`ifdef CHECKSUM_EN
                        proxEstado = CHECK;
`else
                        proxEstado = FEITO;
`endif
                    end
                end
            end
`ifdef CHECKSUM_EN
            CHECK: begin
                if (xfer) proxEstado = (byteIn == soma) ? FEITO : ERRO;
            end
`endif
            FEITO: proxEstado = FEITO;
            ERRO:  proxEstado = ERRO;
            default: proxEstado = CONTA_H;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            memEsc    <= 1'b0;
            memEnd    <= BASE_ADDR;
            memDados  <= 32'h0;
            palavras  <= '0;
            endProx   <= BASE_ADDR;
            fase      <= 2'd0;
            parcial   <= 24'h0;
            contaAlta <= 8'h0;
            total     <= 17'h0;
`ifdef CHECKSUM_EN
            soma      <= 8'h0;
`endif
        end else begin
            memEsc <= escPalavra;
            if (estado == CONTA_H && xfer) contaAlta <= byteIn;
            if (estado == CONTA_L && xfer) total <= nVal;
            if (estado == DADOS && xfer) begin
                fase <= fase + 2'd1;
`ifdef CHECKSUM_EN
                soma <= soma ^ byteIn;
`endif
                if (escPalavra) begin
                    memDados <= {parcial, byteIn};
                    memEnd   <= endProx;
                    endProx  <= endProx + 32'd4;
                    palavras <= palavras + 1'b1;
                end else begin
                    parcial <= {parcial[15:0], byteIn};
                end
            end
        end
    end

endmodule

// File: tb/tb_carregador_programa.sv
// Self-checking bench for carregador_programa.
// Writes are scored against an expected-write queue filled as stimulus is driven.
module tb_carregador_programa;

    localparam int          AW   = 8;
    localparam logic [31:0] BASE = 32'h0;

    logic          clock = 0;
    logic          reset = 0;
    logic [7:0]    byteIn = 0;
    logic          byteValid = 0;
    logic          byteReady;
    logic          memEsc;
    logic [31:0]   memEnd;
    logic [31:0]   memDados;
    logic [AW:0]   palavras;
    logic          pronto;
    logic          erro;

    int nCmp = 0;
    int nBad = 0;

    logic [63:0] sb[$];
    logic [31:0] wordsQ[$];

    carregador_programa #(.ADDR_W(AW), .BASE_ADDR(BASE)) dut (
        .clock(clock), .reset(reset), .byteIn(byteIn),
        .byteValid(byteValid), .byteReady(byteReady),
        .memEsc(memEsc), .memEnd(memEnd), .memDados(memDados),
        .palavras(palavras), .pronto(pronto), .erro(erro)
    );

    always #5 clock = ~clock;

    // Every strobe cycle must match the oldest outstanding expected write.
    always @(negedge clock) begin
        if (!reset && memEsc) begin
            logic [63:0] e;
            nCmp++;
            if (sb.size() == 0) begin
                nBad++;
                $display("FAIL write_unexpected got %h@%h", memDados, memEnd);
            end else begin
                e = sb.pop_front();
                if ({memEnd, memDados} !== e) begin
                    nBad++;
                    $display("FAIL write got %h@%h want %h@%h",
                             memDados, memEnd, e[31:0], e[63:32]);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] want);
        nCmp++;
        if (got !== want) begin
            nBad++;
            $display("FAIL %s got %h want %h", nm, got, want);
        end
    endtask

    task automatic doReset();
        @(negedge clock);
        reset = 1;
        byteValid = 0;
        @(negedge clock);
        reset = 0;
    endtask

    task automatic sendByte(input logic [7:0] b);
        int k;
        k = 0;
        @(negedge clock);
        while (!byteReady && k < 20) begin
            @(negedge clock);
            k++;
        end
        if (!byteReady) begin
            nCmp++;
            nBad++;
            $display("FAIL send_timeout got ready=0 want ready=1");
            return;
        end
        byteValid = 1;
        byteIn = b;
        @(posedge clock);
        #1 byteValid = 0;
        byteIn = 8'hxx;
    endtask

    // Sends count + wordsQ (+ checksum), queueing the expected writes.
    task automatic loadWords(input bit toggle, input bit badSum);
        logic [7:0]  x;
        logic [15:0] n;
        logic [31:0] w;
        x = 8'h00;
        n = 16'(wordsQ.size());
        sendByte(n[15:8]);
        sendByte(n[7:0]);
        for (int k = 0; k < wordsQ.size(); k++) begin
            w = wordsQ[k];
            for (int j = 3; j >= 0; j--) begin
                if (toggle) @(negedge clock);
                if (j == 0) sb.push_back({BASE + 32'(4 * k), w});
                x = x ^ w[8*j +: 8];
                sendByte(w[8*j +: 8]);
            end
        end
`ifdef CHECKSUM_EN
        sendByte(badSum ? (x ^ 8'h01) : x);
`else
        if (badSum) x = 8'h00;
`endif
    endtask

    task automatic endCheck(input string nm);
        chk({nm, "_sb_empty"}, 32'(sb.size()), 0);
        sb.delete();
    endtask

    task automatic test_reset();
        @(negedge clock);
        reset = 1;
        #1;
        chk("rst_ready", byteReady, 0);
        chk("rst_esc", memEsc, 0);
        chk("rst_end", memEnd, BASE);
        chk("rst_dados", memDados, 0);
        chk("rst_pal", palavras, 0);
        chk("rst_pronto", pronto, 0);
        chk("rst_erro", erro, 0);
        @(negedge clock);
        reset = 0;
        #1;
        chk("rst_ready_after", byteReady, 1);
    endtask

    task automatic test_basic(input bit toggle);
        doReset();
        wordsQ = '{32'h8C010004, 32'h00221820};
        loadWords(toggle, 0);
        @(negedge clock);
`ifdef CHECKSUM_EN
        chk("basic_pronto", pronto, 1);
`else
        chk("basic_pronto_early", pronto, 0);
        chk("basic_esc", memEsc, 1);
        @(negedge clock);
        chk("basic_pronto", pronto, 1);
`endif
        chk("basic_pal", palavras, 2);
        chk("basic_ready", byteReady, 0);
        chk("basic_erro", erro, 0);
        chk("basic_hold_end", memEnd, 32'h4);
        chk("basic_hold_dados", memDados, 32'h00221820);
        endCheck("basic");
    endtask

    task automatic test_zero();
        doReset();
        wordsQ = {};
        loadWords(0, 0);
        @(negedge clock);
        chk("zero_pronto", pronto, 1);
        chk("zero_pal", palavras, 0);
        chk("zero_erro", erro, 0);
        endCheck("zero");
    endtask

    task automatic test_oversize();
        doReset();
        sendByte(8'h01);
        sendByte(8'h01);
        @(negedge clock);
        chk("over_erro", erro, 1);
        chk("over_ready", byteReady, 0);
        chk("over_pronto", pronto, 0);
        byteValid = 1;
        for (int i = 0; i < 8; i++) begin
            byteIn = 8'(i);
            @(negedge clock);
        end
        byteValid = 0;
        chk("over_pal", palavras, 0);
        chk("over_erro_hold", erro, 1);
        endCheck("over");
    endtask

    task automatic test_max();
        doReset();
        wordsQ = {};
        for (int i = 0; i < (1 << AW); i++) wordsQ.push_back($urandom);
        loadWords(0, 0);
        @(negedge clock);
        @(negedge clock);
        chk("max_pronto", pronto, 1);
        chk("max_pal", palavras, 32'(1 << AW));
        chk("max_end", memEnd, BASE + 32'(4 * ((1 << AW) - 1)));
        chk("max_erro", erro, 0);
        endCheck("max");
    endtask

`ifdef CHECKSUM_EN
    task automatic test_checksum();
        doReset();
        wordsQ = '{32'h01020304};
        loadWords(0, 0);
        @(negedge clock);
        chk("sum_ok_pronto", pronto, 1);
        chk("sum_ok_erro", erro, 0);
        endCheck("sum_ok");
        doReset();
        loadWords(0, 1);
        @(negedge clock);
        chk("sum_bad_erro", erro, 1);
        chk("sum_bad_pronto", pronto, 0);
        chk("sum_bad_pal", palavras, 1);
        endCheck("sum_bad");
    endtask
`endif

    task automatic test_reset_mid();
        doReset();
        sb.push_back({BASE, 32'h8C010004});
        sendByte(8'h00);
        sendByte(8'h02);
        sendByte(8'h8C);
        sendByte(8'h01);
        sendByte(8'h00);
        sendByte(8'h04);
        sendByte(8'h00);
        sendByte(8'h22);
        @(negedge clock);
        #2 reset = 1;
        #1;
        chk("mid_ready", byteReady, 0);
        chk("mid_esc", memEsc, 0);
        chk("mid_end", memEnd, BASE);
        chk("mid_dados", memDados, 0);
        chk("mid_pal", palavras, 0);
        chk("mid_pronto", pronto, 0);
        chk("mid_erro", erro, 0);
        @(negedge clock);
        reset = 0;
        wordsQ = '{32'hDEADBEEF};
        loadWords(0, 0);
        @(negedge clock);
        @(negedge clock);
        chk("mid_new_pal", palavras, 1);
        chk("mid_new_pronto", pronto, 1);
        chk("mid_new_end", memEnd, BASE);
        endCheck("mid");
    endtask

    initial begin
        test_reset();
        test_basic(0);
        test_basic(1);
        test_zero();
        test_oversize();
        test_max();
`ifdef CHECKSUM_EN
        test_checksum();
`endif
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got running want finished");
        $fatal(1, "timeout");
    end

endmodule
